// File: rtl/inert_intf_seq_if.sv
// -----------------------------------------------------------------------------
// inert_intf_seq_if
//
// Purpose : Command/response handshake between the inertial read sequencer and
//           an external SPI_mstr16 instance.
//
// Signals :
//   wrt      sequencer -> SPI   start a transaction (one-cycle pulse)
//   cmd      sequencer -> SPI   16-bit command word
//   done     SPI -> sequencer   transaction complete (one-cycle pulse)
//   rd_data  SPI -> sequencer   read data; only the low byte is meaningful
//
// Modports: master = sequencer side, slave = SPI engine side.
// -----------------------------------------------------------------------------
interface inert_intf_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface : inert_intf_seq_if

// File: rtl/inert_intf_seq.sv
// -----------------------------------------------------------------------------
// inert_intf_seq
//
// Purpose : Inertial-sensor read sequencer. After a power-up wake delay it
//           writes a fixed four-command configuration to the sensor, then on
//           every data-ready interrupt reads NUM_CH 16-bit channels as
//           2*NUM_CH byte reads (low byte, then high byte) and publishes all
//           channels together with a one-cycle valid strobe.
//
// Parameters:
//   NUM_CH     channels read per interrupt (1..8)
//   CH_ADDR    NUM_CH bytes; byte k is channel k's low-byte register address,
//              the high byte lives at that address + 1
//   WAKE_BITS  wake counter width; wake delay is 2^WAKE_BITS-1 cycles
//   TMO_CYC    interrupt timeout in WAIT, in cycles (timeout build only)
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   INT      in   sensor data-ready, asynchronous level
//   spi      --   master side of inert_intf_seq_if (wrt/cmd/done/rd_data)
//   data     out  NUM_CH*16 channel words, channel k at [16k+15:16k]
//   vld      out  one-cycle pulse when data has been updated
//   rdy      out  sensor configuration complete
//   tmo      out  sticky interrupt-timeout flag
//
// Build option:
//   INERT_TMO_EN  when defined, a WAIT that sees no interrupt for TMO_CYC
//                 cycles sets tmo, drops rdy and re-runs the configuration
//                 (without repeating the wake delay). When undefined, WAIT
//                 waits forever and tmo is tied low.
// -----------------------------------------------------------------------------
module inert_intf_seq #(
  parameter int                   NUM_CH    = 2,
  parameter logic [NUM_CH*8-1:0]  CH_ADDR   = {8'h2C, 8'h22},
  parameter int                   WAKE_BITS = 16,
  parameter int                   TMO_CYC   = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    INT,
  inert_intf_seq_if.master        spi,
  output logic [NUM_CH*16-1:0]    data,
  output logic                    vld,
  output logic                    rdy,
  output logic                    tmo
);

  // ---------------------------------------------------------------------------
  // Local sizes
  // ---------------------------------------------------------------------------
  localparam int NB = 2 * NUM_CH;       // byte reads per frame
  localparam int XW = $clog2(NB);       // width of the read index (>= 1)

  localparam logic [15:0] CFG_CMD0 = 16'h0D02;

  typedef enum logic [2:0] {
    S_WAKE,
    S_INIT,
    S_WAIT,
    S_READ,
    S_VLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Command helpers
  // ---------------------------------------------------------------------------
  // Configuration sequence written once after wake (and again after a timeout).
  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  // Read command for byte transaction x: channel x/2, +1 for the high byte.
  function automatic logic [15:0] rd_cmd(input logic [XW-1:0] x);
    logic [7:0] a;
    a = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == int'(x >> 1)) a = CH_ADDR[8*k +: 8];
    end
    a = a + {7'd0, x[0]};
    return {1'b1, a[6:0], 8'h00};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_q,  state_d;
  logic [WAKE_BITS-1:0]   wake_q,   wake_d;
  logic [1:0]             idx_q,    idx_d;
  logic [XW-1:0]          x_q,      x_d;
  logic [NB*8-1:0]        shadow_q, shadow_d;
  logic [NUM_CH*16-1:0]   data_q,   data_d;
  logic                   rdy_q,    rdy_d;
  logic                   int_meta_q, int_s_q;

  logic                   wrt;
  logic [15:0]            cmd;

`ifdef INERT_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   tmo_q,  tmo_d;
`endif

  // Only the low byte of each SPI read carries register data.
  logic [7:0] unused_rd_hi;
  assign unused_rd_hi = spi.rd_data[15:8];

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first so that no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wake_d   = wake_q;
    idx_d    = idx_q;
    x_d      = x_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    wrt      = 1'b0;
    cmd      = CFG_CMD0;
`ifdef INERT_TMO_EN
    tmo_d    = tmo_q;
    // Counter only advances while sitting in WAIT, so it is zero on entry.
    tcnt_d   = '0;
`endif

    case (state_q)
      S_WAKE: begin
        cmd    = CFG_CMD0;
        wake_d = wake_q + WAKE_BITS'(1);
        if (wake_q == '1) begin
          wrt     = 1'b1;
          state_d = S_INIT;
          idx_d   = 2'd0;
        end
      end

      S_INIT: begin
        cmd = init_cmd(idx_q);
        if (spi.done) begin
          if (idx_q != 2'd3) begin
            // Zero-cycle turnaround: next command goes out with the done.
            wrt   = 1'b1;
            cmd   = init_cmd(idx_q + 2'd1);
            idx_d = idx_q + 2'd1;
          end else begin
            state_d = S_WAIT;
            rdy_d   = 1'b1;
          end
        end
      end

      S_WAIT: begin
        // done is deliberately ignored here (stray or late completions).
        cmd = rd_cmd('0);
        if (int_s_q) begin
          wrt     = 1'b1;
          state_d = S_READ;
          x_d     = '0;
        end
`ifdef INERT_TMO_EN
        else if (tcnt_q == TW'(TMO_CYC - 1)) begin
          // Sensor went quiet: flag it and re-configure without a new wake.
          tmo_d   = 1'b1;
          rdy_d   = 1'b0;
          wrt     = 1'b1;
          cmd     = CFG_CMD0;
          state_d = S_INIT;
          idx_d   = 2'd0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end

      S_READ: begin
        cmd = rd_cmd(x_q);
        if (spi.done) begin
          for (int b = 0; b < NB; b++) begin
            if (XW'(b) == x_q) shadow_d[8*b +: 8] = spi.rd_data[7:0];
          end
          if (x_q != XW'(NB - 1)) begin
            wrt = 1'b1;
            cmd = rd_cmd(x_q + XW'(1));
            x_d = x_q + XW'(1);
          end else begin
            // Publish on the edge that enters VLD so data and vld rise
            // together. Shadow bytes are already in {hi, lo} word order.
            data_d  = shadow_d;
            state_d = S_VLD;
          end
        end
      end

      S_VLD: begin
        cmd     = rd_cmd('0);
        state_d = S_WAIT;
      end

      default: begin
        state_d = S_WAKE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAKE;
      wake_q     <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_q     <= wake_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      // Two-flop synchroniser; raw INT never reaches the FSM.
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

`ifdef INERT_TMO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi.wrt = wrt;
  assign spi.cmd = cmd;
  assign data    = data_q;
  assign vld     = (state_q == S_VLD);
  assign rdy     = rdy_q;

endmodule : inert_intf_seq

// File: tb/tb_inert_intf_seq.sv
// -----------------------------------------------------------------------------
// tb_inert_intf_seq
//
// Directed bench for inert_intf_seq with NUM_CH=2, default channel addresses,
// WAKE_BITS=4 and TMO_CYC=50. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge. The timeout scenario is exercised
// when INERT_TMO_EN is defined, otherwise the bench checks that WAIT idles.
// -----------------------------------------------------------------------------
module tb_inert_intf_seq;

  localparam int          NUM_CH    = 2;
  localparam logic [15:0] CH_ADDR   = {8'h2C, 8'h22};
  localparam int          WAKE_BITS = 4;
  localparam int          TMO_CYC   = 50;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT   = 1'b0;
  logic [31:0] data;
  logic        vld;
  logic        rdy;
  logic        tmo;

  inert_intf_seq_if spi_if ();

  inert_intf_seq #(
    .NUM_CH    (NUM_CH),
    .CH_ADDR   (CH_ADDR),
    .WAKE_BITS (WAKE_BITS),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .INT   (INT),
    .spi   (spi_if),
    .data  (data),
    .vld   (vld),
    .rdy   (rdy),
    .tmo   (tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pulse done (with a read byte) 5 cycles after the call; report the
  // combinational wrt/cmd seen in the done cycle. Returns at posedge+1 of the
  // edge that registered the done.
  task automatic pulse_done(input logic [7:0] b, output logic w, output logic [15:0] c);
    repeat (4) @(posedge clk);
    #1;
    spi_if.done    = 1'b1;
    spi_if.rd_data = {8'hEE, b};
    @(negedge clk);
    w = spi_if.wrt;
    c = spi_if.cmd;
    @(posedge clk);
    #1;
    spi_if.done = 1'b0;
  endtask

  // Bounded wait for wrt, sampled on falling edges.
  task automatic wait_wrt(input int limit, output int n);
    n = 0;
    while (!spi_if.wrt && n < limit) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  // Called just before the first edge after reset release: wrt must stay low
  // for edges 1..14 and be high after edge 15 (FSM leaves WAKE on edge 16).
  task automatic wake_check(input bit late_done);
    int early;
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      if (late_done && i == 3) begin #1; spi_if.done = 1'b1; end
      if (late_done && i == 4) begin #1; spi_if.done = 1'b0; end
      @(negedge clk);
      if (i < 15 && spi_if.wrt) early++;
    end
    check("wake_early_wrt", early, 0);
    check("wake_wrt_at_16", spi_if.wrt, 1'b1);
    check("wake_cmd", spi_if.cmd, 16'h0D02);
  endtask

  logic        w;
  logic [15:0] c;
  int          n;
  int          cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_if.done    = 1'b0;
    spi_if.rd_data = 16'h0000;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_wrt",  spi_if.wrt, 1'b0);
    check("rst_cmd",  spi_if.cmd, 16'h0D02);
    check("rst_vld",  vld, 1'b0);
    check("rst_rdy",  rdy, 1'b0);
    check("rst_tmo",  tmo, 1'b0);
    check("rst_data", data, 32'h0);
    rst_n = 1'b1;

    // ---------------- wake delay ----------------
    wake_check(1'b0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (spi_if.wrt) cnt++;
    end
    check("no_wrt_without_done", cnt, 0);
    check("rdy_during_init", rdy, 1'b0);

    // ---------------- configuration ----------------
    pulse_done(8'h00, w, c);
    check("init1_wrt", w, 1'b1);
    check("init1_cmd", c, 16'h1053);
    pulse_done(8'h00, w, c);
    check("init2_cmd", c, 16'h1150);
    pulse_done(8'h00, w, c);
    check("init3_cmd", c, 16'h1460);
    check("rdy_before_4th", rdy, 1'b0);
    pulse_done(8'h00, w, c);
    check("init4_no_wrt", w, 1'b0);
    @(negedge clk);
    check("rdy_after_init", rdy, 1'b1);
    check("wait_cmd", spi_if.cmd, 16'hA200);

    // done while in WAIT must be ignored
    pulse_done(8'h99, w, c);
    check("wait_done_no_wrt", w, 1'b0);
    @(negedge clk);
    check("wait_done_cmd", spi_if.cmd, 16'hA200);
    check("wait_done_vld", vld, 1'b0);

    // ---------------- frame 1, INT held high ----------------
    @(posedge clk);
    #1 INT = 1'b1;
    @(posedge clk); @(negedge clk);
    check("sync_edge1_no_wrt", spi_if.wrt, 1'b0);
    @(posedge clk); @(negedge clk);
    check("sync_edge2_wrt", spi_if.wrt, 1'b1);
    check("frame_cmd0", spi_if.cmd, 16'hA200);
    pulse_done(8'h12, w, c);
    check("f1_cmd1", c, 16'hA300);
    pulse_done(8'h34, w, c);
    check("f1_cmd2", c, 16'hAC00);
    pulse_done(8'h56, w, c);
    check("f1_cmd3", c, 16'hAD00);
    check("f1_wrt3", w, 1'b1);
    pulse_done(8'h78, w, c);
    check("f1_last_no_wrt", w, 1'b0);
    @(negedge clk);
    check("f1_vld", vld, 1'b1);
    check("f1_data", data, 32'h7856_3412);
    @(posedge clk); @(negedge clk);
    check("f1_vld_single", vld, 1'b0);
    check("f1_b2b_wrt", spi_if.wrt, 1'b1);
    check("f1_data_hold", data, 32'h7856_3412);

    // ---------------- frame 2, INT dropped during READ ----------------
    @(posedge clk);
    #1 INT = 1'b0;
    pulse_done(8'hA1, w, c);
    check("f2_cmd1", c, 16'hA300);
    pulse_done(8'hB2, w, c);
    pulse_done(8'hC3, w, c);
    check("f2_cmd3", c, 16'hAD00);
    pulse_done(8'hD4, w, c);
    @(negedge clk);
    check("f2_vld", vld, 1'b1);
    check("f2_data", data, 32'hD4C3_B2A1);
    @(posedge clk);

`ifdef INERT_TMO_EN
    // ---------------- interrupt timeout ----------------
    @(negedge clk);
    wait_wrt(100, n);
    check("tmo_delay", n, TMO_CYC - 1);
    check("tmo_cmd", spi_if.cmd, 16'h0D02);
    @(posedge clk); @(negedge clk);
    check("tmo_flag", tmo, 1'b1);
    check("tmo_rdy_low", rdy, 1'b0);
    pulse_done(8'h00, w, c);
    check("reinit1_cmd", c, 16'h1053);
    pulse_done(8'h00, w, c);
    pulse_done(8'h00, w, c);
    pulse_done(8'h00, w, c);
    @(negedge clk);
    check("reinit_rdy", rdy, 1'b1);
    INT = 1'b1;
    wait_wrt(10, n);
    check("tmo_frame_start", spi_if.wrt, 1'b1);
    pulse_done(8'h01, w, c);
    INT = 1'b0;
    pulse_done(8'h02, w, c);
    pulse_done(8'h03, w, c);
    pulse_done(8'h04, w, c);
    @(negedge clk);
    check("tmo_frame_vld", vld, 1'b1);
    check("tmo_frame_data", data, 32'h0403_0201);
    check("tmo_sticky", tmo, 1'b1);
`else
    // ---------------- no timeout: WAIT idles ----------------
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (spi_if.wrt) cnt++;
    end
    check("idle_no_wrt", cnt, 0);
    check("idle_tmo", tmo, 1'b0);
    check("idle_rdy", rdy, 1'b1);
    check("idle_data_hold", data, 32'hD4C3_B2A1);
`endif

    // ---------------- reset mid-frame ----------------
    @(posedge clk);
    #1 INT = 1'b1;
    @(negedge clk);
    wait_wrt(10, n);
    check("rst_frame_start", spi_if.wrt, 1'b1);
    pulse_done(8'h11, w, c);
    pulse_done(8'h22, w, c);
    rst_n = 1'b0;
    INT   = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 32'h0);
    check("midrst_vld",  vld, 1'b0);
    check("midrst_rdy",  rdy, 1'b0);
    check("midrst_wrt",  spi_if.wrt, 1'b0);
    check("midrst_cmd",  spi_if.cmd, 16'h0D02);
    check("midrst_tmo",  tmo, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wake_check(1'b1);
    check("midrst_data_after", data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_inert_intf_seq
